// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the set-associative data cache.
//   state_e  - miss-handling FSM states
//   clog2 / off_w / idx_w / tag_w / way_w - derived field widths from the
//   cache geometry parameters (32-bit byte addresses).
package dcache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_MISS        = 3'd1,
    ST_WRITEBACK   = 3'd2,
    ST_REFILL      = 3'd3,
    ST_REFILL_DONE = 3'd4
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int off_w(input int line_bytes);
    return clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int sets);
    return clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int line_bytes);
    return 32 - clog2(sets) - clog2(line_bytes);
  endfunction

  // A direct-mapped cache still needs a one-bit way/pointer field.
  function automatic int way_w(input int ways);
    return (ways > 1) ? clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_way.sv
// dcache_way: one way of the cache - valid, dirty, tag and line storage for
// every set. Single shared index for lookup, word write and line fill.
//   clk_i/rst_i      clock, async active-high reset (valid/dirty only)
//   idx_i            set index for read and write
//   valid_o/dirty_o/tag_o/line_o  contents of the indexed set (combinational)
//   word_we_i        write word_i at bit offset bit_off_i, mark line dirty
//   fill_i           install fill_line_i/fill_tag_i, valid=1 dirty=0
module dcache_way import dcache_pkg::*; #(
  parameter  int SETS       = 32,
  parameter  int LINE_BYTES = 32,
  localparam int LINE_BITS  = 8 * LINE_BYTES,
  localparam int IDX_W      = idx_w(SETS),
  localparam int TAG_W      = tag_w(SETS, LINE_BYTES),
  localparam int BO_W       = off_w(LINE_BYTES) + 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     idx_i,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic [LINE_BITS-1:0] line_o,
  input  logic                 word_we_i,
  input  logic [BO_W-1:0]      bit_off_i,
  input  logic [31:0]          word_i,
  input  logic                 fill_i,
  input  logic [TAG_W-1:0]     fill_tag_i,
  input  logic [LINE_BITS-1:0] fill_line_i
);

  logic [SETS-1:0]      valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: valid_q qualifies them.
  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_line_i;
    end else if (word_we_i) begin
      data_q[idx_i][bit_off_i +: 32] <= word_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_assoc.sv
// dcache_assoc: WAYS-way set-associative write-back, write-allocate data cache.
//   clk_i/rst_i            clock, async active-high reset
//   p1_*                   CPU port: word address/data, read/write strobes,
//                          combinational read data, stall while missing
//   mem_*                  line-wide memory port: enable/write/address/data,
//                          one-cycle ack pulse with refill data
//   hit_cnt_o/miss_cnt_o   saturating access statistics
module dcache_assoc import dcache_pkg::*; #(
  parameter  int WAYS       = 2,
  parameter  int SETS       = 32,
  parameter  int LINE_BYTES = 32,
  localparam int LINE_BITS  = 8 * LINE_BYTES
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          p1_addr_i,
  input  logic [31:0]          p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic                 mem_ack_i,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
);

  localparam int OFF_W = off_w(LINE_BYTES);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(SETS, LINE_BYTES);
  localparam int WAY_W = way_w(WAYS);
  localparam int BO_W  = OFF_W + 3;

  state_e               state_q, state_d;
  logic [TAG_W-1:0]     miss_tag_q;
  logic [IDX_W-1:0]     miss_idx_q;
  logic [WAY_W-1:0]     victim_q, cur_vic, hit_way;
  logic                 victim_vld_q, missed_q, hit, vic_found;
  logic [WAY_W-1:0]     rr_q [SETS];
  logic [31:0]          hit_cnt_q, miss_cnt_q;

  logic [WAYS-1:0]                w_valid, w_dirty, way_hit, w_we, w_fill;
  logic [WAYS-1:0][TAG_W-1:0]     w_tag;
  logic [WAYS-1:0][LINE_BITS-1:0] w_line;
  logic [LINE_BITS-1:0]           rd_line;

  logic [TAG_W-1:0] p1_tag;
  logic [IDX_W-1:0] p1_idx, look_idx;
  logic [BO_W-1:0]  bit_off;
  logic             req, idle, ack_refill;

  assign p1_tag   = p1_addr_i[31 -: TAG_W];
  assign p1_idx   = p1_addr_i[OFF_W +: IDX_W];
  // Bit offset of the addressed word inside the line; byte bits [1:0] dropped.
  assign bit_off  = {p1_addr_i[OFF_W-1:0], 3'b000} & ~BO_W'(31);
  assign req      = p1_MemRead_i | p1_MemWrite_i;
  assign idle     = (state_q == ST_IDLE);
  // Outside IDLE the arrays look at the latched miss set, so a dropped or
  // changed CPU request cannot redirect an in-flight fill.
  assign look_idx = idle ? p1_idx : miss_idx_q;
  assign ack_refill = (state_q == ST_REFILL) && mem_ack_i;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_hit[w] = w_valid[w] && (w_tag[w] == p1_tag);
    assign w_we[w]    = idle && p1_MemWrite_i && way_hit[w];
    assign w_fill[w]  = ack_refill && (victim_q == WAY_W'(w));

    dcache_way #(.SETS(SETS), .LINE_BYTES(LINE_BYTES)) u_way (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .idx_i      (look_idx),
      .valid_o    (w_valid[w]),
      .dirty_o    (w_dirty[w]),
      .tag_o      (w_tag[w]),
      .line_o     (w_line[w]),
      .word_we_i  (w_we[w]),
      .bit_off_i  (bit_off),
      .word_i     (p1_data_i),
      .fill_i     (w_fill[w]),
      .fill_tag_i (miss_tag_q),
      .fill_line_i(mem_data_i)
    );
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
  end

  // Lowest-index invalid way wins; otherwise the set's round-robin pointer.
  always_comb begin
    cur_vic   = rr_q[look_idx];
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!vic_found && !w_valid[w]) begin
        cur_vic   = WAY_W'(w);
        vic_found = 1'b1;
      end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (req && !hit) state_d = ST_MISS;
      ST_MISS:        state_d = (w_valid[cur_vic] && w_dirty[cur_vic]) ? ST_WRITEBACK : ST_REFILL;
      ST_WRITEBACK:   if (mem_ack_i) state_d = ST_REFILL;
      ST_REFILL:      if (mem_ack_i) state_d = ST_REFILL_DONE;
      ST_REFILL_DONE: state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      victim_q     <= '0;
      victim_vld_q <= 1'b0;
      missed_q     <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if (idle && req && !hit) begin
        miss_tag_q <= p1_tag;
        miss_idx_q <= p1_idx;
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      // The first hit after a fill completes a missed access: not a hit.
      if (idle && req && hit && !missed_q && hit_cnt_q != '1)
        hit_cnt_q <= hit_cnt_q + 32'd1;
      missed_q <= idle ? (req && !hit) : missed_q;
      if (state_q == ST_MISS) begin
        victim_q     <= cur_vic;
        victim_vld_q <= w_valid[cur_vic];
      end
      if (ack_refill && victim_vld_q)
        rr_q[miss_idx_q] <= (rr_q[miss_idx_q] == WAY_W'(WAYS - 1)) ? '0
                            : rr_q[miss_idx_q] + WAY_W'(1);
    end
  end

  assign mem_enable_o = (state_q == ST_WRITEBACK) || (state_q == ST_REFILL);
  assign mem_write_o  = (state_q == ST_WRITEBACK);
  assign mem_addr_o   = (state_q == ST_WRITEBACK)
                        ? {w_tag[victim_q], miss_idx_q, {OFF_W{1'b0}}}
                        : {miss_tag_q,      miss_idx_q, {OFF_W{1'b0}}};
  assign mem_data_o   = w_line[victim_q];

  assign rd_line    = w_line[hit_way];
  assign p1_data_o  = rd_line[bit_off +: 32];
  assign p1_stall_o = req && !(idle && hit);
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: directed + random accesses against a reference model.
// The model tracks per-set residency (tag/valid/dirty/pointer) to predict
// hits and memory traffic; data is checked against a flat CPU-visible memory.
module tb_dcache_assoc;
  localparam int LBITS = 256;

  logic             clk = 1'b0, rst;
  logic [31:0]      p1_addr, p1_wdata, p1_rdata, mem_addr, hit_cnt, miss_cnt;
  logic             p1_rd, p1_wr, p1_stall, mem_en, mem_wr, mem_ack;
  logic [LBITS-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dcache_assoc dut (
    .clk_i(clk), .rst_i(rst),
    .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_MemRead_i(p1_rd), .p1_MemWrite_i(p1_wr),
    .p1_data_o(p1_rdata), .p1_stall_o(p1_stall),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_data_i(mem_rdata),
    .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_ack_i(mem_ack),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [LBITS-1:0] obs, input logic [LBITS-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  typedef struct { bit wr; logic [31:0] addr; logic [LBITS-1:0] data; } mtx_t;
  mtx_t             log_q[$];
  logic [LBITS-1:0] back [int unsigned];   // memory-side lines written back
  logic [31:0]      gold [int unsigned];   // CPU-visible words written
  bit               hold;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] la;
    logic [LBITS-1:0] l;
    la = a & 32'hFFFF_FFE0;
    if (back.exists(la)) begin
      l = back[la];
      return l[int'(a[4:2]) * 32 +: 32];
    end
    return init_word({a[31:2], 2'b00});
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return gold.exists(w) ? gold[w] : mem_word(w);
  endfunction

  function automatic logic [LBITS-1:0] gold_line(input logic [31:0] la);
    logic [LBITS-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = gold_word(la + 32'(4 * i));
    return l;
  endfunction

  // Memory responder: random 0-3 cycle latency, one-cycle ack pulse.
  initial begin
    bit busy;
    int dly;
    logic [31:0] caddr;
    bit cwr;
    logic [LBITS-1:0] line;
    busy = 0; dly = 0; caddr = '0; cwr = 0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst) busy = 0;
      else if (mem_en) begin
        if (!busy) begin
          busy = 1; caddr = mem_addr; cwr = mem_wr; dly = $urandom_range(0, 3);
        end
        if (dly > 0) dly--;
        else if (!hold) begin
          chk("mem_stable", {mem_wr, mem_addr}, {cwr, caddr});
          if (mem_wr) begin
            back[mem_addr] = mem_wdata;
            log_q.push_back('{1'b1, mem_addr, mem_wdata});
          end else begin
            for (int i = 0; i < 8; i++) line[i*32 +: 32] = mem_word(mem_addr + 32'(4 * i));
            mem_rdata = line;
            log_q.push_back('{1'b0, mem_addr, '0});
          end
          mem_ack = 1'b1;
          busy = 0;
        end
      end
    end
  end

  // Reference model: residency per set/way, replacement pointer, counters.
  bit          mv [32][2], md [32][2];
  logic [21:0] mt [32][2];
  int          mrr [32];
  int          exp_hit, exp_miss;

  function automatic void model_reset();
    for (int s = 0; s < 32; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < 2; w++) begin mv[s][w] = 0; md[s][w] = 0; mt[s][w] = '0; end
    end
    exp_hit = 0; exp_miss = 0;
  endfunction

  task automatic access(input logic [31:0] a, input bit we, input logic [31:0] wd);
    int s, hw, vic, cyc, n;
    logic [21:0] t;
    bit was_hit, xwb;
    logic [31:0] wba, rfa;
    s = int'(a[9:5]); t = a[31:10]; hw = -1; vic = -1; xwb = 0; wba = '0; rfa = '0;
    for (int w = 0; w < 2; w++) if (mv[s][w] && mt[s][w] == t) hw = w;
    was_hit = (hw >= 0);
    if (!was_hit) begin
      for (int w = 1; w >= 0; w--) if (!mv[s][w]) vic = w;
      if (vic < 0) begin vic = mrr[s]; mrr[s] = (mrr[s] + 1) % 2; end
      xwb = mv[s][vic] && md[s][vic];
      wba = {mt[s][vic], 5'(s), 5'b0};
      rfa = {t, 5'(s), 5'b0};
      mv[s][vic] = 1; md[s][vic] = 0; mt[s][vic] = t; hw = vic;
      exp_miss++;
    end else exp_hit++;
    if (we) md[s][hw] = 1;

    log_q.delete();
    @(posedge clk); #1;
    p1_addr = a; p1_wdata = wd; p1_rd = !we; p1_wr = we;
    @(negedge clk);
    chk("stall_first", p1_stall, !was_hit);
    cyc = 0;
    while (p1_stall && cyc < 100) begin @(negedge clk); cyc++; end
    chk("complete", p1_stall, 1'b0);
    if (!we) chk("rdata", p1_rdata, gold_word(a));
    n = was_hit ? 0 : (xwb ? 2 : 1);
    chk("traffic_n", 32'(log_q.size()), 32'(n));
    if (log_q.size() == n && n > 0) begin
      if (xwb) begin
        chk("wb_addr", {log_q[0].wr, log_q[0].addr}, {1'b1, wba});
        chk("wb_data", log_q[0].data, gold_line(wba));
      end
      chk("rf_addr", {log_q[n-1].wr, log_q[n-1].addr}, {1'b0, rfa});
    end
    if (we) gold[{a[31:2], 2'b00}] = wd;
    @(posedge clk); #1;
    p1_rd = 0; p1_wr = 0;
    @(negedge clk);
    chk("hit_cnt", hit_cnt, 32'(exp_hit));
    chk("miss_cnt", miss_cnt, 32'(exp_miss));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1; p1_addr = '0; p1_wdata = '0; p1_rd = 0; p1_wr = 0; hold = 0;
    model_reset();
    #1;
    chk("rst_mem_en", mem_en, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_counters", {hit_cnt, miss_cnt}, 64'd0);
    chk("rst_stall", p1_stall, 1'b0);

    access(32'h400, 0, '0);             // cold miss, refill 0x400
    access(32'h400, 0, '0);             // hit
    access(32'h404, 1, 32'hDEADBEEF);   // write hit, line becomes dirty
    access(32'h404, 0, '0);
    access(32'h400, 0, '0);
    access(32'h800, 0, '0);             // fills the other way, no write-back
    access(32'h400, 0, '0);
    access(32'hC00, 0, '0);             // evicts dirty 0x400 line
    access(32'h1000, 0, '0);            // evicts clean 0x800 line
    access(32'hC00, 0, '0);

    // Reset during the refill wait abandons the fill.
    hold = 1;
    @(posedge clk); #1;
    p1_addr = 32'h1400; p1_rd = 1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(mem_en && !mem_wr) && cyc < 50);
    chk("reached_refill", {mem_en, mem_wr}, 2'b10);
    #2 rst = 1;
    #1 chk("rst_mid_en", mem_en, 1'b0);
    p1_rd = 0; hold = 0;
    @(negedge clk); @(negedge clk); rst = 0;
    model_reset();
    gold.delete();
    chk("rst_mid_counters", {hit_cnt, miss_cnt}, 64'd0);
    access(32'hC00, 0, '0);             // misses again after reset
    access(32'h1400, 0, '0);

    for (int i = 0; i < 200; i++)
      access((32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 3)) << 5)
             | (32'($urandom_range(0, 7)) << 2), bit'($urandom_range(0, 1)), $urandom);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_assoc.md
DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2: associativity, power of two, 1..8.
REQ-002 SHALL have parameter SETS, default 32: sets per way, power of two.
REQ-003 SHALL have parameter LINE_BYTES, default 32: line size, power of two, at least 4.
REQ-004 SHALL derive the following from the parameters:
- LINE_BITS = 8*LINE_BYTES
- OFF_W = log2(LINE_BYTES)
- IDX_W = log2(SETS)
- TAG_W = 32-IDX_W-OFF_W
REQ-005 clk_i  in  1  single clock, rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 p1_addr_i  in  32  CPU byte address; bits [1:0] ignored, accesses are word-aligned.
REQ-008 p1_data_i  in  32  CPU write data.
REQ-009 p1_MemRead_i / p1_MemWrite_i  in  1 each  CPU request; never both high.
REQ-010 p1_data_o  out  32  read data, combinational, valid when request high and stall low.
REQ-011 p1_stall_o  out  1  high while request pending and not hit.
REQ-012 mem_addr_o  out  32  line-aligned memory address.
REQ-013 mem_data_o  out  LINE_BITS  write-back line data.
REQ-014 mem_data_i  in  LINE_BITS  refill data, valid with mem_ack_i.
REQ-015 mem_enable_o / mem_write_o  out  1 each  memory request / direction.
REQ-016 mem_ack_i  in  1  one-cycle memory completion pulse.
REQ-017 hit_cnt_o / miss_cnt_o  out  32 each  saturating access counters.

Function
REQ-018 Address split SHALL be: offset [OFF_W-1:0], index [OFF_W+IDX_W-1:OFF_W], tag [31:OFF_W+IDX_W].
REQ-019 Per way and set, the block SHALL hold: valid bit, dirty bit, TAG_W tag, LINE_BITS data.
REQ-020 Hit SHALL be a combinational match on any way with valid=1 and equal tag; at most one way matches.
REQ-021 Read hit SHALL return the 32-bit word at offset[OFF_W-1:2] of the hit way in the same cycle, with zero stall.
REQ-022 Write hit SHALL update only that word of the hit way and set its dirty bit at the next edge, with zero stall.
REQ-023 FSM states SHALL be IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE, with these transitions:
- IDLE->MISS on request and no hit
- MISS->WRITEBACK if the victim is valid and dirty, else MISS->REFILL
- WRITEBACK->REFILL on mem_ack_i
- REFILL->REFILL_DONE on mem_ack_i
- REFILL_DONE->IDLE
REQ-024 Victim selection in MISS SHALL be: lowest-index invalid way; else the per-set round-robin pointer.
REQ-025 The round-robin pointer SHALL advance by one mod WAYS only when a valid line is replaced.
REQ-026 WRITEBACK SHALL drive the following, held stable until ack:
- mem_enable_o=1, mem_write_o=1
- mem_addr_o = {victim tag, index, OFF_W zeros}
- mem_data_o = victim line
REQ-027 REFILL SHALL drive mem_enable_o=1, mem_write_o=0 and mem_addr_o = {p1 tag, index, zeros}.
REQ-028 On the refill ack, the victim way SHALL be written with mem_data_i, valid=1, dirty=0, and the new tag.
REQ-029 In REFILL_DONE, mem_enable_o SHALL be 0; the pending access then completes as a hit in IDLE (write-allocate).
REQ-030 Miss-to-completion latency SHALL be 3 cycles plus memory wait, plus the write-back wait if the victim is dirty.
REQ-031 mem_ack_i SHALL be ignored in IDLE, MISS and REFILL_DONE.
REQ-032 hit_cnt_o SHALL increment once per completed access that hit in IDLE without any preceding miss.
REQ-033 miss_cnt_o SHALL increment once per IDLE->MISS transition.
REQ-034 Both counters SHALL saturate at 0xFFFFFFFF.
REQ-035 A request dropped while a miss is in flight SHALL still complete the fill; no write occurs.

Reset
REQ-036 rst_i SHALL asynchronously force:
- FSM to IDLE
- all valid and dirty bits to 0
- all round-robin pointers to 0
- mem_enable_o, mem_write_o and both counters to 0
REQ-037 Reset asserted mid-transaction SHALL abandon it; mem_enable_o falls immediately and the line is not installed.
REQ-038 Data and tag arrays SHALL require no reset.

Structure
REQ-039 A shared package dcache_pkg SHALL hold the FSM state enum and the derived-width functions.
REQ-040 A single sub-module dcache_way SHALL hold one way's valid, dirty, tag and data arrays; it is instantiated WAYS times.

Verification (WAYS=2, SETS=32, LINE_BYTES=32)
REQ-041 Cold read 0x00000400 -> stall, one read with mem_addr_o=0x400, then hit; miss_cnt=1.
REQ-042 Write 0xDEADBEEF to 0x404, then read 0x404 and 0x400 -> 0xDEADBEEF and the original refill word; no memory traffic.
REQ-043 Read 0x800 after REQ-042 -> fills way1 of set 0 with no write-back; 0x400 still hits.
REQ-044 Read 0xC00 next -> evicts dirty way0: write at 0x400 carrying 0xDEADBEEF, then read 0xC00; pointer becomes 1.
REQ-045 Read 0x1000 next -> evicts clean way1 (tag 2) with no write-back.
REQ-046 Assert rst_i during REFILL wait -> mem_enable_o=0 at once; re-reading 0xC00 misses again.
